// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline.
// Result source and load type codes used by MEM/WB.
package mips_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_LINK = 2'b10,
    RES_RSVD = 2'b11
  } res_src_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment and extension.
// Flags misaligned offsets and reserved load types.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  type_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    unique case (off_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      default: byte_s = word_i[31:24];
    endcase
    half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = 32'd0;
    err_o  = 1'b0;
    case (type_i)
      LD_W: begin
        data_o = word_i;
        err_o  = (off_i != 2'd0);
      end
      LD_B:  data_o = {{24{byte_s[7]}}, byte_s};
      LD_BU: data_o = {24'd0, byte_s};
      LD_H: begin
        data_o = {{16{half_s[15]}}, half_s};
        err_o  = off_i[0];
      end
      LD_HU: begin
        data_o = {16'd0, half_s};
        err_o  = off_i[0];
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, result select and regfile write port.
// Also flags bad loads and counts retired instructions.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       LoadTypeM,
  input  logic [4:0]       WriteRegM,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      ReadDataM,
  input  logic [31:0]      PCPlus8M,
  output logic             WE3,
  output logic [4:0]       RA3,
  output logic [31:0]      WD3,
  output logic [31:0]      ResultW,
  output logic             ExcW,
  output logic [CNT_W-1:0] RetireCount
);

  logic             valid_q, valid_d;
  logic             regwr_q, regwr_d;
  logic [1:0]       src_q, src_d;
  logic [2:0]       ltype_q, ltype_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      pc8_q, pc8_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] ld_data;
  logic        ld_err;

  always_comb begin
    valid_d = valid_q;
    regwr_d = regwr_q;
    src_d   = src_q;
    ltype_d = ltype_q;
    wreg_d  = wreg_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc8_d   = pc8_q;
    cnt_d   = cnt_q;
    if (FlushW) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
    end else if (!StallW) begin
      valid_d = ValidM;
      regwr_d = RegWriteM;
      src_d   = ResultSrcM;
      ltype_d = LoadTypeM;
      wreg_d  = WriteRegM;
      alu_d   = ALUOutM;
      rdata_d = ReadDataM;
      pc8_d   = PCPlus8M;
    end
    // the instruction leaving W retires, faulting or not
    if (valid_q && !StallW && !FlushW)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      src_q   <= 2'd0;
      ltype_q <= 3'd0;
      wreg_q  <= 5'd0;
      alu_q   <= 32'd0;
      rdata_q <= 32'd0;
      pc8_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      regwr_q <= regwr_d;
      src_q   <= src_d;
      ltype_q <= ltype_d;
      wreg_q  <= wreg_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc8_q   <= pc8_d;
      cnt_q   <= cnt_d;
    end
  end

  load_align u_align (
    .word_i (rdata_q),
    .off_i  (alu_q[1:0]),
    .type_i (ltype_q),
    .data_o (ld_data),
    .err_o  (ld_err)
  );

  always_comb begin
    unique case (src_q)
      RES_ALU:  ResultW = alu_q;
      RES_LOAD: ResultW = ld_data;
      RES_LINK: ResultW = pc8_q;
      default:  ResultW = 32'd0;
    endcase
  end

  assign ExcW = valid_q &
                (((src_q == RES_LOAD) & ld_err) |
                 (src_q == RES_RSVD));

  assign WE3 = valid_q & regwr_q & ~ExcW & (wreg_q != 5'd0);
  assign RA3 = wreg_q;
  assign WD3 = ResultW;
  assign RetireCount = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a 32-bit and a 4-bit counter copy.
// A negedge regfile model shows split-phase write-then-read.
`timescale 1ns/1ps
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        StallW = 1'b0;
  logic        FlushW = 1'b0;
  logic        ValidM = 1'b0;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'd0;
  logic [2:0]  LoadTypeM = 3'd0;
  logic [4:0]  WriteRegM = 5'd0;
  logic [31:0] ALUOutM = 32'd0;
  logic [31:0] ReadDataM = 32'd0;
  logic [31:0] PCPlus8M = 32'd0;

  logic        WE3, ExcW;
  logic [4:0]  RA3;
  logic [31:0] WD3, ResultW;
  logic [31:0] RetireCount;

  logic        WE3_4, ExcW_4;
  logic [4:0]  RA3_4;
  logic [31:0] WD3_4, ResultW_4;
  logic [3:0]  RetireCount_4;

  int total = 0;
  int bad = 0;
  logic        vw = 1'b0;
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] rf [32];

  always #5 CLK = ~CLK;

  mem_wb_stage #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .LoadTypeM(LoadTypeM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .ReadDataM(ReadDataM), .PCPlus8M(PCPlus8M),
    .WE3(WE3), .RA3(RA3), .WD3(WD3), .ResultW(ResultW),
    .ExcW(ExcW), .RetireCount(RetireCount)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .LoadTypeM(LoadTypeM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .ReadDataM(ReadDataM), .PCPlus8M(PCPlus8M),
    .WE3(WE3_4), .RA3(RA3_4), .WD3(WD3_4), .ResultW(ResultW_4),
    .ExcW(ExcW_4), .RetireCount(RetireCount_4)
  );

  always @(negedge CLK)
    if (WE3) rf[RA3] <= WD3;

  task automatic drive(input logic v, input logic rw,
                       input logic [1:0] src, input logic [2:0] lt,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic [31:0] pc8);
    ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt;
    WriteRegM = rd; ALUOutM = alu; ReadDataM = rdat; PCPlus8M = pc8;
  endtask

  // advance one rising edge, tracking expected ValidW and retire count
  task automatic step();
    if (vw && !StallW && !FlushW) exp_cnt = exp_cnt + 1;
    if (FlushW) vw = 1'b0;
    else if (!StallW) vw = ValidM;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (WE3 !== 1'b0 || RA3 !== 5'd0 || WD3 !== 32'd0 ||
        ResultW !== 32'd0 || ExcW !== 1'b0 || RetireCount !== 32'd0) begin
      bad++;
      $display("FAIL reset: we=%b ra=%0d wd=%h res=%h exc=%b cnt=%0d req all zero",
               WE3, RA3, WD3, ResultW, ExcW, RetireCount);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_alu();
    drive(1, 1, 2'b00, 3'd0, 5'd8, 32'h1234, 32'h0, 32'h0);
    step();
    total++;
    if (WE3 !== 1'b1 || RA3 !== 5'd8 || WD3 !== 32'h1234) begin
      bad++;
      $display("FAIL alu_wb: we=%b ra=%0d wd=%h req we=1 ra=8 wd=00001234",
               WE3, RA3, WD3);
    end
    @(negedge CLK);
    #1;
    total++;
    if (rf[8] !== 32'h1234) begin
      bad++;
      $display("FAIL rf_read_r8: got %h req 00001234", rf[8]);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lt [4];
    logic [1:0]  off [4];
    logic [31:0] expv [4];
    lt[0] = 3'b001; off[0] = 2'd3; expv[0] = 32'hFFFFFF80;
    lt[1] = 3'b010; off[1] = 2'd3; expv[1] = 32'h00000080;
    lt[2] = 3'b011; off[2] = 2'd2; expv[2] = 32'hFFFF80FF;
    lt[3] = 3'b100; off[3] = 2'd0; expv[3] = 32'h00007F01;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'b01, lt[i], 5'd9, {30'h400, off[i]},
            32'h80FF7F01, 32'h0);
      step();
      total++;
      if (WD3 !== expv[i] || WE3 !== 1'b1 || ExcW !== 1'b0) begin
        bad++;
        $display("FAIL load_%0d: wd=%h we=%b exc=%b req wd=%h we=1 exc=0",
                 i, WD3, WE3, ExcW, expv[i]);
      end
    end
  endtask

  task automatic test_exc();
    logic [2:0] lt [4];
    logic [1:0] off [4];
    logic [1:0] src [4];
    lt[0] = 3'b000; off[0] = 2'd2; src[0] = 2'b01;
    lt[1] = 3'b011; off[1] = 2'd1; src[1] = 2'b01;
    lt[2] = 3'b101; off[2] = 2'd0; src[2] = 2'b01;
    lt[3] = 3'b000; off[3] = 2'd0; src[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, src[i], lt[i], 5'd10, {30'h400, off[i]},
            32'h80FF7F01, 32'h0);
      step();
      total++;
      if (ExcW !== 1'b1 || WE3 !== 1'b0) begin
        bad++;
        $display("FAIL exc_%0d: exc=%b we=%b req exc=1 we=0",
                 i, ExcW, WE3);
      end
    end
    total++;
    if (WD3 !== 32'd0) begin
      bad++;
      $display("FAIL rsvd_src_zero: wd=%h req 00000000", WD3);
    end
    drive(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    total++;
    if (RetireCount !== exp_cnt) begin
      bad++;
      $display("FAIL exc_retire: cnt=%0d req %0d", RetireCount, exp_cnt);
    end
  endtask

  task automatic test_r0_link();
    drive(1, 1, 2'b00, 3'd0, 5'd0, 32'hDEAD, 32'h0, 32'h0);
    step();
    total++;
    if (WE3 !== 1'b0 || WD3 !== 32'hDEAD) begin
      bad++;
      $display("FAIL r0_guard: we=%b wd=%h req we=0 wd=0000dead", WE3, WD3);
    end
    drive(1, 1, 2'b10, 3'd0, 5'd31, 32'h5555, 32'h0, 32'h00400010);
    step();
    total++;
    if (WE3 !== 1'b1 || RA3 !== 5'd31 || WD3 !== 32'h00400010) begin
      bad++;
      $display("FAIL link: we=%b ra=%0d wd=%h req we=1 ra=31 wd=00400010",
               WE3, RA3, WD3);
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 2'b00, 3'd0, 5'd5, 32'hAAAA, 32'h0, 32'h0);
    step();
    drive(1, 1, 2'b00, 3'd0, 5'd6, 32'hBBBB, 32'h0, 32'h0);
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (WE3 !== 1'b1 || RA3 !== 5'd5 || WD3 !== 32'hAAAA ||
          RetireCount !== exp_cnt) begin
        bad++;
        $display("FAIL stall_%0d: we=%b ra=%0d wd=%h cnt=%0d req 1 5 0000aaaa %0d",
                 i, WE3, RA3, WD3, RetireCount, exp_cnt);
      end
    end
    FlushW = 1'b1;
    step();
    total++;
    if (WE3 !== 1'b0 || ExcW !== 1'b0 || RetireCount !== exp_cnt) begin
      bad++;
      $display("FAIL flush_stall: we=%b exc=%b cnt=%0d req we=0 exc=0 cnt=%0d",
               WE3, ExcW, RetireCount, exp_cnt);
    end
    FlushW = 1'b0;
    StallW = 1'b0;
    drive(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_async_reset();
    drive(1, 1, 2'b00, 3'd0, 5'd7, 32'h77, 32'h0, 32'h0);
    step();
    drive(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    total++;
    if (WE3 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_we: we=%b req 1", WE3);
    end
    #2;
    RST = 1'b1;
    #1;
    total++;
    if (WE3 !== 1'b0 || RetireCount !== 32'd0 || RetireCount_4 !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: we=%b cnt=%0d cnt4=%0d req 0 0 0",
               WE3, RetireCount, RetireCount_4);
    end
    vw = 1'b0;
    exp_cnt = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_wrap();
    drive(1, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) step();
    total++;
    if (RetireCount_4 !== 4'hF || RetireCount !== 32'd15) begin
      bad++;
      $display("FAIL pre_wrap: cnt4=%0d cnt=%0d req 15 15",
               RetireCount_4, RetireCount);
    end
    step();
    total++;
    if (RetireCount_4 !== 4'h0 || RetireCount !== 32'd16) begin
      bad++;
      $display("FAIL wrap: cnt4=%0d cnt=%0d req 0 16",
               RetireCount_4, RetireCount);
    end
    drive(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    #12;
    test_reset();
    @(posedge CLK);
    #1;
    test_alu();
    test_loads();
    test_exc();
    test_r0_link();
    test_stall_flush();
    drive(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    total++;
    if (RetireCount !== exp_cnt || RetireCount_4 !== exp_cnt[3:0]) begin
      bad++;
      $display("FAIL retire_total: cnt=%0d cnt4=%0d req %0d %0d",
               RetireCount, RetireCount_4, exp_cnt, exp_cnt[3:0]);
    end
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
